inst_prefetch_buffer: RTL and testbench

// Sequential instruction prefetcher between the core fetch port (addr/data/stall) and the
// on-chip instruction memory (fixed-latency read port, e.g. flash/ROM with clock enable).

---
 rtl/inst_prefetch_buffer_if.sv | 33 +++
 rtl/inst_prefetch_buffer.sv | 155 +++++++++++++++
 tb/tb_inst_prefetch_buffer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_buffer_if.sv
// Fetch/memory bundle for the instruction prefetcher.
// Core side: inst_addr in; inst_data/inst_stall out.
// Memory side: mem_addr/mem_rd out; mem_rdata in.
// The master modport is the prefetcher; slave is the
// core plus the instruction memory around it.
interface inst_prefetch_buffer_if #(
    parameter int AW = 16
) ();
    logic [31:0]   inst_addr;
    logic [31:0]   inst_data;
    logic          inst_stall;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [31:0]   mem_rdata;

    modport master (
        input  inst_addr,
        input  mem_rdata,
        output inst_data,
        output inst_stall,
        output mem_addr,
        output mem_rd
    );

    modport slave (
        output inst_addr,
        output mem_rdata,
        input  inst_data,
        input  inst_stall,
        input  mem_addr,
        input  mem_rd
    );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher: streams words from a
// fixed-latency memory into a small FIFO ahead of the core.
// Ports: clk, reset (async, active high), bus (master):
//   inst_addr -> inst_data/inst_stall (core fetch port)
//   mem_addr/mem_rd -> mem_rdata LAT cycles later
module inst_prefetch_buffer #(
    parameter int          DEPTH      = 4,
    parameter int          LAT        = 1,
    parameter int          AW         = 16,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic                          clk,
    input  logic                          reset,
    inst_prefetch_buffer_if.master        bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + LAT + 1) + 1;

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [31:0]   fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   fifo_count;

    // One valid bit per outstanding read; bit LAT-1 lines
    // up with the cycle its data sits on mem_rdata.
    logic [LAT-1:0] inflight;
    logic [CW-1:0]  inflight_count;
    logic [CW-1:0]  occupancy;

    logic [31:0] exp_addr;
    logic [31:0] fetch_ptr;

    logic match;
    logic fifo_empty;
    logic push;
    logic pop;
    logic issue;
    logic redirect;
    logic stall;

    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_count = inflight_count + CW'(inflight[i]);
        end
    end

    // Credit counts queued plus outstanding words, so a
    // returning read always has a free FIFO slot.
    assign occupancy  = CW'(fifo_count) + inflight_count;
    assign match      = bus.inst_addr[31:2] == exp_addr[31:2];
    assign fifo_empty = fifo_count == '0;
    assign push       = inflight[LAT-1];

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        redirect = 1'b0;
        pop      = 1'b0;
        stall    = 1'b1;
        unique case (state)
            S_RUN: begin
                if (!match) begin
                    redirect = 1'b1;
                    state_nx = S_FLUSH;
                end else begin
                    if (!fifo_empty) begin
                        pop   = 1'b1;
                        stall = 1'b0;
                    end
                    issue = occupancy < CW'(DEPTH);
                end
            end
            S_FLUSH: begin
                // Pipeline and FIFO were just cleared, so
                // the first read of the new stream is free.
                issue    = 1'b1;
                state_nx = S_RUN;
            end
        endcase
    end

    assign bus.inst_stall = stall;
    assign bus.inst_data  = fifo_mem[rd_ptr];
    assign bus.mem_addr   = fetch_ptr[AW+1:2];
    // Held low while reset is asserted, not just after it.
    assign bus.mem_rd     = issue & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RUN;
            inflight  <= '0;
            exp_addr  <= RESET_ADDR;
            fetch_ptr <= RESET_ADDR;
        end else if (redirect) begin
            // Drops in-flight reads, including any word on
            // mem_rdata during this cycle.
            state     <= state_nx;
            inflight  <= '0;
            exp_addr  <= {bus.inst_addr[31:2], 2'b00};
            fetch_ptr <= {bus.inst_addr[31:2], 2'b00};
        end else begin
            state    <= state_nx;
            inflight <= (inflight << 1) | LAT'(issue);
            if (issue) begin
                fetch_ptr <= fetch_ptr + 32'd4;
            end
            if (pop) begin
                exp_addr <= exp_addr + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push && !redirect) begin
            fifo_mem[wr_ptr] <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Scoreboard bench for inst_prefetch_buffer: two instances
// (LAT=1/AW=16 and LAT=3/AW=4), one active at a time.
module tb_inst_prefetch_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0;
    logic        rst1;
    logic        act;
    logic [31:0] core_addr;

    inst_prefetch_buffer_if #(.AW(16)) if0 ();
    inst_prefetch_buffer_if #(.AW(4))  if1 ();

    assign if0.inst_addr = core_addr;
    assign if1.inst_addr = core_addr;

    inst_prefetch_buffer #(
        .DEPTH(4), .LAT(1), .AW(16), .RESET_ADDR(32'h0)
    ) u0 (
        .clk(clk), .reset(rst0), .bus(if0.master)
    );

    inst_prefetch_buffer #(
        .DEPTH(4), .LAT(3), .AW(4), .RESET_ADDR(32'h38)
    ) u1 (
        .clk(clk), .reset(rst1), .bus(if1.master)
    );

    // Memories: word i holds A000_0000+i; not reset, so
    // reads issued before a reset still come back after it.
    logic        v0 = 1'b0;
    logic [15:0] a0 = '0;
    always @(posedge clk) begin
        v0 <= if0.mem_rd;
        a0 <= if0.mem_addr;
    end
    assign if0.mem_rdata = v0 ? 32'hA000_0000 + {16'b0, a0}
                              : 32'hDEAD_BEEF;

    logic [2:0] v1 = '0;
    logic [3:0] a1 [3];
    always @(posedge clk) begin
        v1    <= {v1[1:0], if1.mem_rd};
        a1[0] <= if1.mem_addr;
        a1[1] <= a1[0];
        a1[2] <= a1[1];
    end
    assign if1.mem_rdata = v1[2] ? 32'hA000_0000 + {28'b0, a1[2]}
                                 : 32'hDEAD_BEEF;

    logic        a_rst;
    logic        a_stall;
    logic        a_rd;
    logic [31:0] a_data;
    logic [31:0] a_maddr;
    int          a_count;
    assign a_rst   = act ? rst1 : rst0;
    assign a_stall = act ? if1.inst_stall : if0.inst_stall;
    assign a_rd    = act ? if1.mem_rd : if0.mem_rd;
    assign a_data  = act ? if1.inst_data : if0.inst_data;
    assign a_maddr = act ? {28'b0, if1.mem_addr}
                         : {16'b0, if0.mem_addr};
    assign a_count = act ? int'(u1.fifo_count)
                         : int'(u0.fifo_count);

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int addr;
    } iss_t;

    logic [31:0] sb_q [$];
    iss_t        ilog [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] m;
        m = act ? 32'hF : 32'hFFFF;
        return 32'hA000_0000 + ((a >> 2) & m);
    endfunction

    // Monitor: every accepted instruction pops one
    // expected word; every read issue is logged.
    always @(negedge clk) begin
        if (!a_rst) begin
            if (!a_stall) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_data: got %h", a_data);
                end else begin
                    check("inst_data", a_data, sb_q.pop_front());
                end
            end
            if (a_rd) ilog.push_back('{cyc, int'(a_maddr)});
            check("fifo_bound", 32'(a_count <= 4), 32'd1);
        end
    end

    // Core: present a, wait for stall=0, optionally check
    // the number of stalled cycles, then move on.
    task automatic fetch(input logic [31:0] a, input int exp_w);
        int w;
        w = 0;
        core_addr = a;
        sb_q.push_back(word_of(a));
        @(negedge clk);
        while (a_stall && w <= 50) begin
            w++;
            @(negedge clk);
        end
        if (w > 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_timeout: addr %h got %0d stalls", a, w);
            void'(sb_q.pop_back());
        end else if (exp_w >= 0) begin
            check($sformatf("stalls@%h", a), w, exp_w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string nm, input int idx,
                             input int addr, input int c);
        if (ilog.size() <= idx) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0d issues required > %0d",
                     nm, ilog.size(), idx);
        end else begin
            check({nm, "_addr"}, ilog[idx].addr, addr);
            if (c >= 0) check({nm, "_cyc"}, ilog[idx].cyc, c);
        end
    endtask

    task automatic check_reset(input logic [31:0] ma);
        check("rst_stall", a_stall, 1);
        check("rst_data", a_data, 0);
        check("rst_mem_rd", a_rd, 0);
        check("rst_mem_addr", a_maddr, ma);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int jc;
        act       = 1'b0;
        rst0      = 1'b1;
        rst1      = 1'b1;
        core_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset(32'h0);

        // LAT=1: fill latency then one word per cycle.
        rst0 = 1'b0;
        fetch(32'h0, 2);
        for (int i = 1; i <= 5; i++) fetch(32'(4 * i), 0);

        // Jump 0x14 -> 0x40: three stall cycles, no
        // issue in the redirect cycle, new stream only.
        ilog.delete();
        jc = cyc;
        fetch(32'h40, 3);
        check_log("jmp0_iss0", 0, 32'h10, jc + 1);
        check_log("jmp0_iss1", 1, 32'h11, jc + 2);
        fetch(32'h44, 0);
        fetch(32'h4A, 0);
        fetch(32'h4C, 0);
        rst0 = 1'b1;

        // LAT=3, AW=4, start 0x38: wraps 14,15,0,1 and
        // stops issuing once DEPTH words are owed.
        act = 1'b1;
        @(posedge clk);
        #1;
        check_reset(32'd14);
        ilog.delete();
        core_addr = 32'h38;
        rst1 = 1'b0;
        base = cyc;
        fetch(32'h38, 4);
        fetch(32'h3C, -1);
        fetch(32'h40, -1);
        fetch(32'h44, -1);
        fetch(32'h48, -1);
        check_log("wrap_iss0", 0, 14, base);
        check_log("wrap_iss1", 1, 15, base + 1);
        check_log("wrap_iss2", 2, 0, base + 2);
        check_log("wrap_iss3", 3, 1, base + 3);
        check_log("credit_iss4", 4, 2, base + 5);

        // Jump while a response is on mem_rdata.
        check("jmp1_ret_same_cycle", 32'(v1[2]), 1);
        ilog.delete();
        jc = cyc;
        fetch(32'h20, 5);
        check_log("jmp1_iss0", 0, 8, jc + 1);
        fetch(32'h24, -1);

        // Reset with reads outstanding.
        rst1 = 1'b1;
        #1;
        check_reset(32'd14);
        @(posedge clk);
        #1;
        ilog.delete();
        rst1 = 1'b0;
        base = cyc;
        fetch(32'h38, 4);
        check_log("rst_iss0", 0, 14, base);
        fetch(32'h3C, -1);
        rst1 = 1'b1;

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
